flash_read_seq: RTL and testbench

Sequences a SPI flash READ transaction for the boot path: drives CSB/SCK/MOSI, issues command plus 24-bit address, and shifts MISO into 32-bit words. Words are handed to the housekeeping/Wishbone side over a valid/ready handshake, with SCK stalled on backpressure. The block sits between the flash pins and the housekeeping FSM; the host bypass mux is outside it.

---
 rtl/flash_seq_pkg.sv | 20 ++
 rtl/flash_read_seq_if.sv | 11 +
 rtl/flash_read_seq_sck_gen.sv | 49 ++++
 rtl/flash_read_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_flash_read_seq.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_seq_pkg.sv
// Shared types and constants for the SPI flash read sequencer.
package flash_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_STALL,
    ST_GAP
  } state_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam int         ADDR_BITS     = 24;
  localparam int         WORD_BITS     = 32;
  localparam int         DUMMY_BITS    = 8;

endpackage

// File: rtl/flash_read_seq_if.sv
// Word stream from the flash sequencer to the housekeeping side (valid/ready).
interface flash_read_seq_if;

  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/flash_read_seq_sck_gen.sv
// SCK divider: CLK_DIV sys clocks low, then CLK_DIV high; enable low parks SCK low
// and restarts the low phase. rise_o/fall_o flag the cycle whose edge toggles SCK.
module sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          term;

  assign term   = en_i && (cnt_q == DW'(CLK_DIV - 1));
  assign rise_o = term && !sck_q;
  assign fall_o = term && sck_q;
  assign sck_o  = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (term) begin
      cnt_d = '0;
      sck_d = !sck_q;
    end else begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/flash_read_seq.sv
// SPI flash READ sequencer (mode 0): command + 24-bit address, then 32-bit words
// over valid/ready with SCK stalled on backpressure. FLASH_FAST_READ_EN selects 0x0B + 8 dummy clocks.
//   state    | meaning
//   IDLE     | CSB high, waiting for start
//   CMD      | shifting 8 command bits
//   ADDR     | shifting 24 address bits
//   DUMMY    | 8 dummy clocks (fast read only)
//   DATA     | sampling MISO into the next word
//   STALL    | SCK parked low, a finished word waits for the consumer
//   GAP      | CSB high for CS_HIGH cycles before returning to IDLE
module flash_read_seq
  import flash_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_HIGH = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [23:0]          start_addr_i,
  input  logic [CNT_W-1:0]     word_count_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 flash_csb_o,
  output logic                 flash_clk_o,
  output logic                 flash_mosi_o,
  input  logic                 flash_miso_i,
  flash_read_seq_if.master     word_if
);

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] CMD       = CMD_FAST_READ;
  localparam bit         USE_DUMMY = 1'b1;
`else
  localparam logic [7:0] CMD       = CMD_READ;
  localparam bit         USE_DUMMY = 1'b0;
`endif

  localparam int unsigned GW = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;

  state_e           state_q, state_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [31:0]      tx_q, tx_d;
  logic [31:0]      shreg_q, shreg_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             valid_q, valid_d;
  logic             pending_q, pending_d;
  logic             last_q, last_d;
  logic             wdone_q, wdone_d;
  logic             aborted_q, aborted_d;
  logic             csb_q, csb_d;
  logic             done_q, done_d;
  logic             sck_en, sck_rise, sck_fall, hs;
  logic [31:0]      word_in;

  // Abort gates SCK in the same cycle so the clock is low when CSB rises.
  assign sck_en  = (state_q inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA}) && !abort_i;
  assign hs      = valid_q && word_if.word_ready;
  assign word_in = {shreg_q[30:0], flash_miso_i};

  sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (sck_en),
    .sck_o  (flash_clk_o),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    shreg_d   = shreg_q;
    wdata_d   = wdata_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    last_d    = last_q;
    wdone_d   = wdone_q;
    aborted_d = aborted_q;
    csb_d     = csb_q;
    done_d    = 1'b0;

    if (hs) begin
      rem_d   = rem_q - CNT_W'(1);
      valid_d = 1'b0;
      if (pending_q) begin
        wdata_d   = shreg_q;
        valid_d   = 1'b1;
        pending_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (word_count_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = ST_CMD;
            csb_d     = 1'b0;
            tx_d      = {CMD, start_addr_i};
            rem_d     = word_count_i;
            bit_cnt_d = '0;
            last_d    = 1'b0;
            wdone_d   = 1'b0;
            pending_d = 1'b0;
            aborted_d = 1'b0;
          end
        end
      end
      ST_CMD, ST_ADDR, ST_DUMMY: begin
        if (sck_fall) begin
          tx_d      = {tx_q[30:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (state_q == ST_CMD && bit_cnt_q == 5'd7) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
          end else if (state_q == ST_ADDR && bit_cnt_q == 5'(ADDR_BITS - 1)) begin
            state_d   = USE_DUMMY ? ST_DUMMY : ST_DATA;
            bit_cnt_d = '0;
          end else if (state_q == ST_DUMMY && bit_cnt_q == 5'(DUMMY_BITS - 1)) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (sck_rise) begin
          shreg_d   = word_in;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(WORD_BITS - 1)) begin
            wdone_d = 1'b1;
            last_d  = (rem_q == (CNT_W'(valid_q) + CNT_W'(1)));
            if (!valid_q || hs) begin
              wdata_d = word_in;
              valid_d = 1'b1;
            end else begin
              pending_d = 1'b1;
            end
          end
        end
        // Word boundary: finish the high phase, then park if nothing more may be shifted.
        if (sck_fall && wdone_q) begin
          wdone_d = 1'b0;
          if (last_q || (pending_q && !hs)) state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (rem_d == '0) begin
          state_d = ST_GAP;
          csb_d   = 1'b1;
          gap_d   = GW'(CS_HIGH - 1);
        end else if (pending_q && hs && !last_q) begin
          state_d = ST_DATA;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d   = ST_IDLE;
          done_d    = !aborted_q;
          aborted_d = 1'b0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_i && (state_q inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_STALL})) begin
      state_d   = ST_GAP;
      csb_d     = 1'b1;
      tx_d      = '0;
      valid_d   = 1'b0;
      pending_d = 1'b0;
      aborted_d = 1'b1;
      gap_d     = GW'(CS_HIGH - 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      shreg_q   <= '0;
      wdata_q   <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      last_q    <= 1'b0;
      wdone_q   <= 1'b0;
      aborted_q <= 1'b0;
      csb_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      shreg_q   <= shreg_d;
      wdata_q   <= wdata_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      wdone_q   <= wdone_d;
      aborted_q <= aborted_d;
      csb_q     <= csb_d;
      done_q    <= done_d;
    end
  end

  assign busy_o             = (state_q != ST_IDLE);
  assign done_o             = done_q;
  assign flash_csb_o        = csb_q;
  assign flash_mosi_o       = tx_q[31];
  assign word_if.word_data  = wdata_q;
  assign word_if.word_valid = valid_q;

endmodule

// File: tb/tb_flash_read_seq.sv
// Bench for flash_read_seq: behavioural SPI flash model plus a word scoreboard.
module tb_flash_read_seq;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned CS_HIGH = 8;
  localparam int unsigned CNT_W   = 16;
`ifdef FLASH_FAST_READ_EN
  localparam int         HDR     = 40;
  localparam logic [7:0] EXP_CMD = 8'h0B;
`else
  localparam int         HDR     = 32;
  localparam logic [7:0] EXP_CMD = 8'h03;
`endif

  logic             clk, rst_n, start, abort;
  logic [23:0]      start_addr;
  logic [CNT_W-1:0] word_count;
  logic             busy, done, csb, sck, mosi, miso;

  flash_read_seq_if wif();

  flash_read_seq #(.CLK_DIV(CLK_DIV), .CS_HIGH(CS_HIGH), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .start_addr_i (start_addr),
    .word_count_i (word_count),
    .abort_i      (abort),
    .busy_o       (busy),
    .done_o       (done),
    .flash_csb_o  (csb),
    .flash_clk_o  (sck),
    .flash_mosi_o (mosi),
    .flash_miso_i (miso),
    .word_if      (wif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0;
  int          n_done = 0, n_hs = 0, n_sck = 0, n_csbf = 0;
  int          m_bits = 0;
  logic [7:0]  m_cmd;
  logic [23:0] m_addr;
  logic [31:0] exp_q[$];
  time         t_csb, t_valid;
  bit          first_pend = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] mdl_word(input logic [23:0] a, input int n);
    return 32'hDEADBEEF + 32'(n) * 32'h01234567 + {8'h00, a - 24'h001000};
  endfunction

  // Flash model: captures command/address on SCK rise, drives data on SCK fall.
  always @(negedge csb) begin
    m_bits = 0;
    n_csbf++;
    t_csb = $time;
    first_pend = 1;
  end

  always @(posedge sck) begin
    if (csb === 1'b0) begin
      if (m_bits < 8) m_cmd = {m_cmd[6:0], mosi};
      else if (m_bits < 32) m_addr = {m_addr[22:0], mosi};
      m_bits++;
      n_sck++;
    end
  end

  always @(negedge sck) begin : drv
    int idx;
    logic [31:0] w;
    if (csb === 1'b0 && m_bits >= HDR) begin
      idx  = m_bits - HDR;
      w    = mdl_word(m_addr, idx / 32);
      miso = w[31 - (idx % 32)];
    end
  end

  always @(posedge wif.word_valid) begin
    if (first_pend) begin
      t_valid = $time;
      first_pend = 0;
    end
  end

  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (rst_n) begin
      if (done) n_done++;
      if (wif.word_valid && wif.word_ready) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 32'hxxxxxxxx;
        chk("word", wif.word_data, e);
        n_hs++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic [23:0] a, input int cnt);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = a;
    word_count = CNT_W'(cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(mdl_word(a, i));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int d0;
    int k;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < max) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(tag, 32'(n_done - d0), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_csb"}, csb, 1'b1);
    chk({tag, "_sck"}, sck, 1'b0);
    chk({tag, "_mosi"}, mosi, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_valid"}, wif.word_valid, 1'b0);
    chk({tag, "_data"}, wif.word_data, 32'h0);
  endtask

  initial begin
    int d0, c0, h0, s0, k;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    start_addr = '0; word_count = '0; miso = 1'b0;
    wif.word_ready = 1'b1;
    tick(3);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick(2);

    // Single word, continuous ready
    n_sck = 0;
    d0 = n_done;
    start_txn(24'h001000, 1);
    chk("t1_csb_low", csb, 1'b0);
    chk("t1_busy", busy, 1'b1);
    chk("t1_mosi_b7", mosi, EXP_CMD[7]);
    wait_done("t1_done", 2000);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_cmd", m_cmd, EXP_CMD);
    chk("t1_addr", m_addr, 24'h001000);
    chk("t1_sck_cnt", 32'(n_sck), 32'(HDR + 32));
    chk("t1_latency", 32'((t_valid - t_csb) / 10), 32'((2 * (HDR + 32) - 1) * CLK_DIV));
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    tick(5);
    chk("t1_done_once", 32'(n_done - d0), 32'd1);

    // Zero-length request
    c0 = n_csbf;
    d0 = n_done;
    start_txn(24'h000100, 0);
    chk("t2_done", done, 1'b1);
    chk("t2_busy", busy, 1'b0);
    tick(20);
    chk("t2_csb_quiet", 32'(n_csbf - c0), 32'd0);
    chk("t2_done_cnt", 32'(n_done - d0), 32'd1);

    // Backpressure after second word
    h0 = n_hs;
    start_txn(24'h020000, 4);
    k = 0;
    while (n_hs - h0 < 2 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
    wif.word_ready = 1'b0;
    chk("t3_two_words", 32'(n_hs - h0), 32'd2);
    tick(300);
    s0 = n_sck;
    tick(100);
    chk("t3_sck_frozen", 32'(n_sck - s0), 32'd0);
    chk("t3_sck_low", sck, 1'b0);
    chk("t3_csb_low", csb, 1'b0);
    chk("t3_valid_held", wif.word_valid, 1'b1);
    wif.word_ready = 1'b1;
    wait_done("t3_done", 2000);
    chk("t3_all_words", 32'(n_hs - h0), 32'd4);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort in the address phase
    d0 = n_done;
    start_txn(24'h0ABC00, 2);
    k = 0;
    while (m_bits < 16 && k < 500) begin
      @(posedge clk);
      k++;
    end
    chk("t4_reach_addr", 32'(m_bits >= 16), 32'd1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_csb_high", csb, 1'b1);
    chk("t4_sck_low", sck, 1'b0);
    chk("t4_valid_low", wif.word_valid, 1'b0);
    abort = 1'b0;
    exp_q.delete();
    tick(CS_HIGH + 4);
    chk("t4_no_done", 32'(n_done - d0), 32'd0);
    chk("t4_idle", busy, 1'b0);
    start_txn(24'h0ABC00, 2);
    wait_done("t4_retry_done", 2000);
    chk("t4_cmd", m_cmd, EXP_CMD);
    chk("t4_addr", m_addr, 24'h0ABC00);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset during data
    start_txn(24'h003000, 2);
    k = 0;
    while (m_bits < HDR + 10 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    start_txn(24'h004400, 3);
    wait_done("t5_done", 3000);
    chk("t5_addr", m_addr, 24'h004400);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
